// File: rtl/uniform_word_gen_if.sv
// Command and word-stream signals of the uniform word generator.
// The master modport is the generator side; the slave modport is its environment.
interface uniform_word_gen_if #(
  parameter int W     = 5,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [CNT_W-1:0] cmd_len;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic             done;
  logic             busy;

  modport master (
    input  cmd_valid, cmd_mode, cmd_len, out_ready,
    output cmd_ready, out_valid, out_data, out_last, done, busy
  );

  modport slave (
    output cmd_valid, cmd_mode, cmd_len, out_ready,
    input  cmd_ready, out_valid, out_data, out_last, done, busy
  );
endinterface

// File: rtl/uniform_word_gen.sv
// Burst source of all-0s / all-1s / alternating / walking-one words on a
// valid/ready stream, with a one-cycle done pulse after each burst.
module uniform_word_gen #(
  parameter int W     = 5,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  uniform_word_gen_if.master  bus
);
  localparam int PW = $clog2(W);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] idx_q;
  logic [PW-1:0]    pos_q;
  logic             done_q;

  logic accept, xfer, last;

  assign accept = (state_q == IDLE) && bus.cmd_valid;
  assign xfer   = (state_q == SEND) && bus.out_ready;
  assign last   = (idx_q == len_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (bus.cmd_len != '0)) state_d = SEND;
      SEND:    if (xfer && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // pos_q tracks idx mod W alongside idx so the walking-one needs no divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
      pos_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (accept && (bus.cmd_len == '0)) || (xfer && last);
      if (accept) begin
        mode_q <= bus.cmd_mode;
        len_q  <= bus.cmd_len;
        idx_q  <= '0;
        pos_q  <= '0;
      end else if (xfer) begin
        idx_q <= idx_q + CNT_W'(1);
        pos_q <= (pos_q == PW'(W - 1)) ? '0 : pos_q + PW'(1);
      end
    end
  end

  always_comb begin
    bus.cmd_ready = (state_q == IDLE);
    bus.busy      = (state_q == SEND);
    bus.out_valid = (state_q == SEND);
    bus.out_last  = (state_q == SEND) && last;
    bus.done      = done_q;
    bus.out_data  = '0;
    if (state_q == SEND) begin
      case (mode_q)
        2'b00: bus.out_data = '0;
        2'b01: bus.out_data = '1;
        2'b10: bus.out_data = idx_q[0] ? '1 : '0;
        default: begin
          for (int unsigned b = 0; b < W; b++)
            bus.out_data[b] = (pos_q == PW'(b));
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uniform_word_gen.sv
// Directed, table-driven bench for uniform_word_gen: one record per clock
// cycle of stimulus and expected outputs, plus a hand-written reset sequence.
module tb_uniform_word_gen;
  logic clk = 1'b0;
  logic rst;

  uniform_word_gen_if #(.W(5), .CNT_W(8)) bus ();

  uniform_word_gen #(.W(5), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cv;
    logic [1:0] mode;
    logic [7:0] len;
    logic       ordy;
    logic       ov;
    logic [4:0] od;
    logic       ol;
    logic       dn;
    logic       cr;
    logic       bz;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic cv, input logic [1:0] mode, input logic [7:0] len,
                     input logic ordy, input logic ov, input logic [4:0] od,
                     input logic ol, input logic dn, input logic cr, input logic bz);
    vec_t v;
    v.cv = cv; v.mode = mode; v.len = len; v.ordy = ordy;
    v.ov = ov; v.od = od; v.ol = ol; v.dn = dn; v.cr = cr; v.bz = bz;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int step, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", nm, step, got, exp);
    end
  endtask

  task automatic chk_all(input int step, input logic ov, input logic [4:0] od,
                         input logic ol, input logic dn, input logic cr, input logic bz);
    chk("out_valid", step, {7'd0, bus.out_valid}, {7'd0, ov});
    chk("out_data",  step, {3'd0, bus.out_data},  {3'd0, od});
    chk("out_last",  step, {7'd0, bus.out_last},  {7'd0, ol});
    chk("done",      step, {7'd0, bus.done},      {7'd0, dn});
    chk("cmd_ready", step, {7'd0, bus.cmd_ready}, {7'd0, cr});
    chk("busy",      step, {7'd0, bus.busy},      {7'd0, bz});
  endtask

  // Inputs are driven 1 time unit after a rising edge, outputs checked on the falling edge.
  task automatic drive(input logic r, input logic cv, input logic [1:0] mode,
                       input logic [7:0] len, input logic ordy);
    rst = r;
    bus.cmd_valid = cv;
    bus.cmd_mode  = mode;
    bus.cmd_len   = len;
    bus.out_ready = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 2'b00, 8'd0, 1'b0);
    next_cycle();
    next_cycle();

    //   cv mode  len    ordy  ov od        ol dn cr bz
    add(0, 2'b00, 8'd0,  0,    0, 5'b00000, 0, 0, 1, 0); // reset state
    // all-1s, len 3, ready held high
    add(1, 2'b01, 8'd3,  1,    0, 5'b00000, 0, 0, 1, 0);
    add(0, 2'b00, 8'd0,  1,    1, 5'b11111, 0, 0, 0, 1);
    add(0, 2'b00, 8'd0,  1,    1, 5'b11111, 0, 0, 0, 1);
    add(0, 2'b00, 8'd0,  1,    1, 5'b11111, 1, 0, 0, 1);
    add(0, 2'b00, 8'd0,  1,    0, 5'b00000, 0, 1, 1, 0);
    add(0, 2'b00, 8'd0,  1,    0, 5'b00000, 0, 0, 1, 0);
    // empty burst
    add(1, 2'b10, 8'd0,  1,    0, 5'b00000, 0, 0, 1, 0);
    add(0, 2'b00, 8'd0,  1,    0, 5'b00000, 0, 1, 1, 0);
    add(0, 2'b00, 8'd0,  1,    0, 5'b00000, 0, 0, 1, 0);
    // alternating, len 4, ready toggling
    add(1, 2'b10, 8'd4,  1,    0, 5'b00000, 0, 0, 1, 0);
    add(0, 2'b00, 8'd0,  1,    1, 5'b00000, 0, 0, 0, 1);
    add(0, 2'b00, 8'd0,  0,    1, 5'b11111, 0, 0, 0, 1);
    add(0, 2'b00, 8'd0,  1,    1, 5'b11111, 0, 0, 0, 1);
    add(0, 2'b00, 8'd0,  0,    1, 5'b00000, 0, 0, 0, 1);
    add(0, 2'b00, 8'd0,  1,    1, 5'b00000, 0, 0, 0, 1);
    add(0, 2'b00, 8'd0,  0,    1, 5'b11111, 1, 0, 0, 1);
    add(0, 2'b00, 8'd0,  1,    1, 5'b11111, 1, 0, 0, 1);
    add(0, 2'b00, 8'd0,  0,    0, 5'b00000, 0, 1, 1, 0);
    // walking-one, len 7, with a second command held during SEND
    add(1, 2'b11, 8'd7,  1,    0, 5'b00000, 0, 0, 1, 0);
    add(1, 2'b01, 8'd2,  1,    1, 5'b00001, 0, 0, 0, 1);
    add(1, 2'b01, 8'd2,  1,    1, 5'b00010, 0, 0, 0, 1);
    add(1, 2'b01, 8'd2,  1,    1, 5'b00100, 0, 0, 0, 1);
    add(1, 2'b01, 8'd2,  1,    1, 5'b01000, 0, 0, 0, 1);
    add(1, 2'b01, 8'd2,  1,    1, 5'b10000, 0, 0, 0, 1);
    add(1, 2'b01, 8'd2,  1,    1, 5'b00001, 0, 0, 0, 1);
    add(1, 2'b01, 8'd2,  1,    1, 5'b00010, 1, 0, 0, 1);
    add(1, 2'b01, 8'd2,  1,    0, 5'b00000, 0, 1, 1, 0); // accepted in done cycle
    add(0, 2'b00, 8'd0,  0,    1, 5'b11111, 0, 0, 0, 1);
    add(0, 2'b00, 8'd0,  1,    1, 5'b11111, 0, 0, 0, 1);
    add(0, 2'b00, 8'd0,  1,    1, 5'b11111, 1, 0, 0, 1);
    add(0, 2'b00, 8'd0,  1,    0, 5'b00000, 0, 1, 1, 0);
    add(0, 2'b00, 8'd0,  1,    0, 5'b00000, 0, 0, 1, 0);

    foreach (vq[i]) begin
      drive(1'b0, vq[i].cv, vq[i].mode, vq[i].len, vq[i].ordy);
      @(negedge clk);
      chk_all(i, vq[i].ov, vq[i].od, vq[i].ol, vq[i].dn, vq[i].cr, vq[i].bz);
      next_cycle();
    end

    // Mid-burst reset held two cycles alongside a new command and a ready handshake.
    drive(1'b0, 1'b1, 2'b01, 8'd5, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, 2'b00, 8'd0, 1'b1);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk_all(100, 1'b1, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 2'b11, 8'd3, 1'b1);
    next_cycle();
    @(negedge clk);
    chk_all(101, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);
    next_cycle();
    @(negedge clk);
    chk_all(102, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 2'b00, 8'd0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      @(negedge clk);
      chk_all(103 + k, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
